// File: rtl/ysyx_25040109_arbiter_if.sv
// AXI4-Lite bundle shared by the IFU, LSU and crossbar-facing ports of the arbiter.
// The master modport is the side that issues requests; slave is the side that answers them.
interface ysyx_25040109_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ysyx_25040109_arbiter.sv
// Round-robin arbiter merging the IFU (read-only) and LSU ports onto one AXI4-Lite master,
// granting one complete transaction at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no grant; arbitrate between pending IFU and LSU requests
//   I_AR   | IFU granted, forwarding its read address
//   I_R    | IFU granted, waiting for the read data handshake
//   L_AR   | LSU granted for a read, forwarding its read address
//   L_R    | LSU granted for a read, waiting for the read data handshake
//   L_W    | LSU granted for a write, forwarding AW and W independently
//   L_B    | LSU granted for a write, waiting for the write response
module ysyx_25040109_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25040109_arbiter_if.slave        ifu,
    ysyx_25040109_arbiter_if.slave        lsu,
    ysyx_25040109_arbiter_if.master       out
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_I_AR = 3'd1,
        S_I_R  = 3'd2,
        S_L_AR = 3'd3,
        S_L_R  = 3'd4,
        S_L_W  = 3'd5,
        S_L_B  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_grant;
    logic   w_next_last_grant;
    logic   r_aw_done;
    logic   w_next_aw_done;
    logic   r_w_done;
    logic   w_next_w_done;

    logic   w_ifu_req;
    logic   w_lsu_req;
    logic   w_aw_fire;
    logic   w_w_fire;
    logic   w_unused_ifu;

    assign w_ifu_req = ifu.arvalid;
    assign w_lsu_req = lsu.arvalid | lsu.awvalid;

    // The IFU port never writes; its write-side inputs are intentionally ignored.
    assign w_unused_ifu = ^{ifu.awvalid, ifu.awaddr, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.bready};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_aw_done    <= w_next_aw_done;
            r_w_done     <= w_next_w_done;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_aw_done    = r_aw_done;
        w_next_w_done     = r_w_done;
        w_aw_fire         = 1'b0;
        w_w_fire          = 1'b0;

        ifu.arready = 1'b0;
        ifu.rvalid  = 1'b0;
        ifu.rdata   = {DATA_W{1'b0}};
        ifu.rresp   = 2'b00;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bvalid  = 1'b0;
        ifu.bresp   = 2'b00;

        lsu.arready = 1'b0;
        lsu.rvalid  = 1'b0;
        lsu.rdata   = {DATA_W{1'b0}};
        lsu.rresp   = 2'b00;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bvalid  = 1'b0;
        lsu.bresp   = 2'b00;

        out.arvalid = 1'b0;
        out.araddr  = {ADDR_W{1'b0}};
        out.rready  = 1'b0;
        out.awvalid = 1'b0;
        out.awaddr  = {ADDR_W{1'b0}};
        out.wvalid  = 1'b0;
        out.wdata   = {DATA_W{1'b0}};
        out.wstrb   = {STRB_W{1'b0}};
        out.bready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // On a tie the master that did not finish last wins; writes beat reads on LSU.
                if (w_ifu_req && (!w_lsu_req || r_last_grant)) begin
                    w_next_state = S_I_AR;
                end else if (w_lsu_req) begin
                    w_next_state = lsu.awvalid ? S_L_W : S_L_AR;
                end
            end

            S_I_AR: begin
                out.arvalid = ifu.arvalid;
                out.araddr  = ifu.araddr;
                ifu.arready = out.arready;
                if (ifu.arvalid && out.arready) begin
                    w_next_state = S_I_R;
                end
            end

            S_I_R: begin
                ifu.rvalid = out.rvalid;
                ifu.rdata  = out.rdata;
                ifu.rresp  = out.rresp;
                out.rready = ifu.rready;
                if (out.rvalid && ifu.rready) begin
                    w_next_state      = S_IDLE;
                    w_next_last_grant = 1'b0;
                end
            end

            S_L_AR: begin
                out.arvalid = lsu.arvalid;
                out.araddr  = lsu.araddr;
                lsu.arready = out.arready;
                if (lsu.arvalid && out.arready) begin
                    w_next_state = S_L_R;
                end
            end

            S_L_R: begin
                lsu.rvalid = out.rvalid;
                lsu.rdata  = out.rdata;
                lsu.rresp  = out.rresp;
                out.rready = lsu.rready;
                if (out.rvalid && lsu.rready) begin
                    w_next_state      = S_IDLE;
                    w_next_last_grant = 1'b1;
                end
            end

            S_L_W: begin
                // AW and W complete independently; each is masked once it has fired.
                out.awvalid = lsu.awvalid & ~r_aw_done;
                out.awaddr  = lsu.awaddr;
                lsu.awready = out.awready & ~r_aw_done;
                out.wvalid  = lsu.wvalid & ~r_w_done;
                out.wdata   = lsu.wdata;
                out.wstrb   = lsu.wstrb;
                lsu.wready  = out.wready & ~r_w_done;

                w_aw_fire = lsu.awvalid & out.awready & ~r_aw_done;
                w_w_fire  = lsu.wvalid & out.wready & ~r_w_done;

                if (w_aw_fire) begin
                    w_next_aw_done = 1'b1;
                end
                if (w_w_fire) begin
                    w_next_w_done = 1'b1;
                end
                if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) begin
                    w_next_state   = S_L_B;
                    w_next_aw_done = 1'b0;
                    w_next_w_done  = 1'b0;
                end
            end

            S_L_B: begin
                lsu.bvalid = out.bvalid;
                lsu.bresp  = out.bresp;
                out.bready = lsu.bready;
                if (out.bvalid && lsu.bready) begin
                    w_next_state      = S_IDLE;
                    w_next_last_grant = 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_arbiter.sv
// Scoreboard bench for the two-master AXI4-Lite arbiter: tasks push expected handshake events,
// a negedge monitor logs observed handshakes, and each task compares the two in order.
module tb_ysyx_25040109_arbiter;

    localparam logic [3:0] K_IAR = 4'd0;
    localparam logic [3:0] K_LAR = 4'd1;
    localparam logic [3:0] K_AW  = 4'd2;
    localparam logic [3:0] K_W   = 4'd3;
    localparam logic [3:0] K_IR  = 4'd4;
    localparam logic [3:0] K_LR  = 4'd5;
    localparam logic [3:0] K_B   = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] val;
        logic [3:0]  aux;
    } ev_t;

    logic clk;
    logic rst;

    ysyx_25040109_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_if ();
    ysyx_25040109_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_if ();
    ysyx_25040109_arbiter_if #(.ADDR_W(32), .DATA_W(32)) out_if ();

    ysyx_25040109_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_if),
        .lsu (lsu_if),
        .out (out_if)
    );

    int          n_checks;
    int          n_fail;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         ev_o;
    ev_t         ev_e;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp;
    int          slv_aw_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Handshake monitor, evaluated mid-cycle so every logged event fires on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_if.arvalid && out_if.arready)
                obs_q.push_back(ev_t'({(ifu_if.arready ? K_IAR : K_LAR), out_if.araddr, 4'h0}));
            if (out_if.awvalid && out_if.awready)
                obs_q.push_back(ev_t'({K_AW, out_if.awaddr, 4'h0}));
            if (out_if.wvalid && out_if.wready)
                obs_q.push_back(ev_t'({K_W, out_if.wdata, out_if.wstrb}));
            if (ifu_if.rvalid && ifu_if.rready)
                obs_q.push_back(ev_t'({K_IR, ifu_if.rdata, 2'b00, ifu_if.rresp}));
            if (lsu_if.rvalid && lsu_if.rready)
                obs_q.push_back(ev_t'({K_LR, lsu_if.rdata, 2'b00, lsu_if.rresp}));
            if (lsu_if.bvalid && lsu_if.bready)
                obs_q.push_back(ev_t'({K_B, 32'h0, 2'b00, lsu_if.bresp}));
        end
    end

    // Downstream slave model: arready/wready always high, awready after an optional stall,
    // one read response per AR and one write response once both AW and W have been taken.
    initial begin : slave_model
        bit ar_f, r_f, aw_f, w_f, b_f, aw_seen, w_seen;
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        out_if.arready = 1'b1;
        out_if.rvalid  = 1'b0;
        out_if.rdata   = 32'h0;
        out_if.rresp   = 2'b00;
        out_if.awready = 1'b1;
        out_if.wready  = 1'b1;
        out_if.bvalid  = 1'b0;
        out_if.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            ar_f = out_if.arvalid && out_if.arready;
            r_f  = out_if.rvalid && out_if.rready;
            aw_f = out_if.awvalid && out_if.awready;
            w_f  = out_if.wvalid && out_if.wready;
            b_f  = out_if.bvalid && out_if.bready;
            @(posedge clk);
            #1;
            if (!rst) begin
                out_if.rvalid = 1'b0;
                out_if.bvalid = 1'b0;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
            end else begin
                if (r_f) out_if.rvalid = 1'b0;
                if (ar_f) begin
                    out_if.rvalid = 1'b1;
                    out_if.rdata  = slv_rdata;
                    out_if.rresp  = slv_rresp;
                end
                if (b_f) out_if.bvalid = 1'b0;
                if (aw_f) aw_seen = 1'b1;
                if (w_f) w_seen = 1'b1;
                if (aw_seen && w_seen) begin
                    out_if.bvalid = 1'b1;
                    out_if.bresp  = 2'b00;
                    aw_seen = 1'b0;
                    w_seen  = 1'b0;
                end
            end
            out_if.awready = (slv_aw_stall == 0);
            if (slv_aw_stall > 0) slv_aw_stall--;
        end
    end

    task automatic ifu_read(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        ifu_if.arvalid = 1'b1;
        ifu_if.araddr  = addr;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = ifu_if.arready;
            @(posedge clk);
            #1;
        end
        ifu_if.arvalid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ifu_ar_timeout: addr %h got no arready required arready within 300 cycles", addr);
        end
    endtask

    task automatic lsu_read(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        lsu_if.arvalid = 1'b1;
        lsu_if.araddr  = addr;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = lsu_if.arready;
            @(posedge clk);
            #1;
        end
        lsu_if.arvalid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lsu_ar_timeout: addr %h got no arready required arready within 300 cycles", addr);
        end
    endtask

    task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_ok, w_ok;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        @(posedge clk);
        #1;
        lsu_if.awvalid = 1'b1;
        lsu_if.awaddr  = addr;
        lsu_if.wvalid  = 1'b1;
        lsu_if.wdata   = data;
        lsu_if.wstrb   = strb;
        for (int c = 0; c < 300 && !(aw_ok && w_ok); c++) begin
            @(negedge clk);
            if (lsu_if.awvalid && lsu_if.awready) aw_ok = 1'b1;
            if (lsu_if.wvalid && lsu_if.wready) w_ok = 1'b1;
            @(posedge clk);
            #1;
            if (aw_ok) lsu_if.awvalid = 1'b0;
            if (w_ok) lsu_if.wvalid = 1'b0;
        end
        lsu_if.awvalid = 1'b0;
        lsu_if.wvalid  = 1'b0;
        n_checks++;
        if (!(aw_ok && w_ok)) begin
            n_fail++;
            $display("FAIL lsu_write_timeout: aw_ok=%0d w_ok=%0d required both 1", aw_ok, w_ok);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_if.arvalid = 1'b1;
        lsu_if.arvalid = 1'b1;
        lsu_if.awvalid = 1'b1;
        lsu_if.wvalid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready,
                 ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid,
                 lsu_if.awready, lsu_if.wready, lsu_if.bvalid} !== 12'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got nonzero valid/ready required all 0");
            end
        end
        ifu_if.arvalid = 1'b0;
        lsu_if.arvalid = 1'b0;
        lsu_if.awvalid = 1'b0;
        lsu_if.wvalid  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got out valids/readys %b required 00000",
                     {out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready});
        end
    endtask

    task automatic test_ifu_alone();
        slv_rdata = 32'hDEADBEEF;
        slv_rresp = 2'b00;
        exp_q.push_back(ev_t'({K_IAR, 32'h80000000, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'hDEADBEEF, 4'h0}));
        fork
            ifu_read(32'h80000000);
            begin
                @(posedge clk);
                @(negedge clk);
                n_checks++;
                if (out_if.arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ifu_bubble: out_arvalid got %b required 0", out_if.arvalid);
                end
                @(negedge clk);
                n_checks++;
                if (out_if.arvalid !== 1'b1 || out_if.araddr !== 32'h80000000) begin
                    n_fail++;
                    $display("FAIL ifu_ar_forward: got arvalid=%b araddr=%h required 1/80000000",
                             out_if.arvalid, out_if.araddr);
                end
                n_checks++;
                if ({lsu_if.arready, lsu_if.rvalid, lsu_if.awready, lsu_if.wready, lsu_if.bvalid} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL ifu_lsu_quiet: got lsu handshake outputs nonzero required 0");
                end
            end
        join
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ifu_alone count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL ifu_alone event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        slv_rdata = 32'h11111111;
        slv_rresp = 2'b00;
        // IFU wins the first tie after reset; its immediate re-request then loses to the waiting LSU.
        exp_q.push_back(ev_t'({K_IAR, 32'h80000004, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'h11111111, 4'h0}));
        exp_q.push_back(ev_t'({K_AW, 32'h10000000, 4'h0}));
        exp_q.push_back(ev_t'({K_W, 32'h00000041, 4'h1}));
        exp_q.push_back(ev_t'({K_B, 32'h0, 4'h0}));
        exp_q.push_back(ev_t'({K_IAR, 32'h80000008, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'h11111111, 4'h0}));
        fork
            begin
                ifu_read(32'h80000004);
                ifu_read(32'h80000008);
            end
            lsu_write(32'h10000000, 32'h00000041, 4'h1);
        join
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL round_robin count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL round_robin event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_write_stall();
        slv_aw_stall = 3;
        exp_q.push_back(ev_t'({K_W, 32'hA5A5A5A5, 4'hC}));
        exp_q.push_back(ev_t'({K_AW, 32'h10000004, 4'h0}));
        exp_q.push_back(ev_t'({K_B, 32'h0, 4'h0}));
        lsu_write(32'h10000004, 32'hA5A5A5A5, 4'hC);
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL write_stall count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL write_stall event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_write_before_read();
        slv_rdata = 32'h12345678;
        exp_q.push_back(ev_t'({K_AW, 32'h10000008, 4'h0}));
        exp_q.push_back(ev_t'({K_W, 32'h00000055, 4'hF}));
        exp_q.push_back(ev_t'({K_B, 32'h0, 4'h0}));
        exp_q.push_back(ev_t'({K_LAR, 32'h30000000, 4'h0}));
        exp_q.push_back(ev_t'({K_LR, 32'h12345678, 4'h0}));
        fork
            lsu_write(32'h10000008, 32'h00000055, 4'hF);
            lsu_read(32'h30000000);
        join
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL write_first count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL write_first event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_decerr_stall();
        bit found;
        slv_rdata = 32'h0;
        slv_rresp = 2'b11;
        ifu_if.rready = 1'b0;
        exp_q.push_back(ev_t'({K_IAR, 32'h20000000, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'h0, 4'h3}));
        exp_q.push_back(ev_t'({K_LAR, 32'h30000004, 4'h0}));
        exp_q.push_back(ev_t'({K_LR, 32'h0, 4'h3}));
        fork
            begin
                ifu_read(32'h20000000);
                found = 1'b0;
                for (int c = 0; c < 50 && !found; c++) begin
                    @(negedge clk);
                    found = ifu_if.rvalid;
                end
                n_checks++;
                if (!found) begin
                    n_fail++;
                    $display("FAIL decerr_rvalid: got no ifu_rvalid required rvalid within 50 cycles");
                end
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if ({ifu_if.rvalid, ifu_if.rresp} !== 3'b111) begin
                        n_fail++;
                        $display("FAIL decerr_hold: cycle %0d got rvalid=%b rresp=%b required 1/11",
                                 k, ifu_if.rvalid, ifu_if.rresp);
                    end
                    n_checks++;
                    if ({out_if.arvalid, out_if.awvalid, lsu_if.arready} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL decerr_no_regrant: cycle %0d got %b required 000",
                                 k, {out_if.arvalid, out_if.awvalid, lsu_if.arready});
                    end
                    if (k < 3) @(negedge clk);
                end
                @(posedge clk);
                #1;
                ifu_if.rready = 1'b1;
            end
            lsu_read(32'h30000004);
        join
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL decerr count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL decerr event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        slv_rresp = 2'b00;
    endtask

    task automatic test_async_reset();
        bit found;
        slv_rdata = 32'hCAFEF00D;
        exp_q.push_back(ev_t'({K_IAR, 32'h80000020, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'hCAFEF00D, 4'h0}));
        exp_q.push_back(ev_t'({K_AW, 32'h10000010, 4'h0}));
        exp_q.push_back(ev_t'({K_W, 32'h00000077, 4'h3}));
        ifu_read(32'h80000020);
        for (int c = 0; c < 100 && obs_q.size() < 2; c++) @(negedge clk);
        lsu_if.bready = 1'b0;
        lsu_write(32'h10000010, 32'h00000077, 4'h3);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            found = lsu_if.bvalid;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL areset_reach_lb: got no lsu_bvalid required bvalid within 50 cycles");
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_if.arvalid, out_if.awvalid, out_if.wvalid, out_if.rready, out_if.bready,
             ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid,
             lsu_if.awready, lsu_if.wready, lsu_if.bvalid} !== 12'b0) begin
            n_fail++;
            $display("FAIL areset_outputs: got nonzero valid/ready required all 0 immediately");
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL areset_pre count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL areset_pre event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lsu_if.bready = 1'b1;
        // The last completed grant before reset was IFU, so only a restored last_grant puts IFU first.
        exp_q.push_back(ev_t'({K_IAR, 32'h80000024, 4'h0}));
        exp_q.push_back(ev_t'({K_IR, 32'hCAFEF00D, 4'h0}));
        exp_q.push_back(ev_t'({K_LAR, 32'h30000010, 4'h0}));
        exp_q.push_back(ev_t'({K_LR, 32'hCAFEF00D, 4'h0}));
        fork
            ifu_read(32'h80000024);
            lsu_read(32'h30000010);
        join
        for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL areset_post count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_o = obs_q.pop_front();
            ev_e = exp_q.pop_front();
            n_checks++;
            if (ev_o !== ev_e) begin
                n_fail++;
                $display("FAIL areset_post event: got %h required %h", ev_o, ev_e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        slv_rdata    = 32'h0;
        slv_rresp    = 2'b00;
        slv_aw_stall = 0;
        rst          = 1'b0;

        ifu_if.arvalid = 1'b0;
        ifu_if.araddr  = 32'h0;
        ifu_if.rready  = 1'b1;
        ifu_if.awvalid = 1'b0;
        ifu_if.awaddr  = 32'h0;
        ifu_if.wvalid  = 1'b0;
        ifu_if.wdata   = 32'h0;
        ifu_if.wstrb   = 4'h0;
        ifu_if.bready  = 1'b0;

        lsu_if.arvalid = 1'b0;
        lsu_if.araddr  = 32'h0;
        lsu_if.rready  = 1'b1;
        lsu_if.awvalid = 1'b0;
        lsu_if.awaddr  = 32'h0;
        lsu_if.wvalid  = 1'b0;
        lsu_if.wdata   = 32'h0;
        lsu_if.wstrb   = 4'h0;
        lsu_if.bready  = 1'b1;

        test_reset();
        test_ifu_alone();
        test_round_robin();
        test_write_stall();
        test_write_before_read();
        test_decerr_stall();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25040109_arbiter.md
Name: ysyx_25040109_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter sitting directly upstream of the address-decoding crossbar.
- Merges the IFU instruction-fetch port (read-only) and the LSU data port (read/write) into the single upstream master port the crossbar consumes.
- Grants one whole transaction at a time (address through response) using round-robin between masters.
- Only one outstanding transaction exists system-wide.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- ifu_arvalid in 1; ifu_arready out 1; ifu_araddr in ADDR_W: IFU read address channel.
- ifu_rvalid out 1; ifu_rready in 1; ifu_rdata out DATA_W; ifu_rresp out 2: IFU read data channel.
- lsu_arvalid in 1; lsu_arready out 1; lsu_araddr in ADDR_W: LSU read address channel.
- lsu_rvalid out 1; lsu_rready in 1; lsu_rdata out DATA_W; lsu_rresp out 2: LSU read data channel.
- lsu_awvalid in 1; lsu_awready out 1; lsu_awaddr in ADDR_W: LSU write address channel.
- lsu_wvalid in 1; lsu_wready out 1; lsu_wdata in DATA_W; lsu_wstrb in DATA_W/8: LSU write data channel.
- lsu_bvalid out 1; lsu_bready in 1; lsu_bresp out 2: LSU write response channel.
- out_ar*/out_r*/out_aw*/out_w*/out_b*: same signal set as the LSU port, directions mirrored; drives the crossbar upstream port.

Behaviour:
- Registers:
  - state: IDLE, I_AR, I_R, L_AR, L_R, L_W, L_B.
  - last_grant: 0 = IFU, 1 = LSU.
  - aw_done, w_done.
- Reset (rst=0, asynchronous): state=IDLE, last_grant=LSU (IFU wins first tie), aw_done=w_done=0.
- Output values in reset and in IDLE:
  - All valids and readys driven on every port are 0.
  - Data, addr and resp outputs are don't-care, driven 0 in IDLE.
- IDLE arbitration:
  - Requests: ifu_req = ifu_arvalid; lsu_req = lsu_arvalid | lsu_awvalid.
  - Only one requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - LSU grant goes to L_W if lsu_awvalid, else L_AR. Write beats read, consistent with the crossbar's AW-over-AR rule.
  - Transition takes effect next cycle: one bubble cycle of arbitration latency. Nothing is forwarded in IDLE.
- I_AR / L_AR:
  - out_arvalid and out_araddr come from the granted master; granted arready = out_arready.
  - out_awvalid = out_wvalid = 0 (so the crossbar AR path is never blocked).
  - On AR fire, go to I_R / L_R.
- I_R / L_R:
  - Granted rvalid/rdata/rresp = out_r*; out_rready = granted rready.
  - On R fire, go to IDLE and set last_grant to that master.
  - Resp is passed through unmodified, including DECERR 2'b11.
- L_W, AW channel: out_awvalid = lsu_awvalid & !aw_done; lsu_awready = out_awready & !aw_done.
- L_W, W channel: out_wvalid = lsu_wvalid & !w_done; lsu_wready = out_wready & !w_done.
- L_W, done flags: set on the respective fire. When (aw_done | aw_fire) & (w_done | w_fire), go to L_B and clear both flags. AW and W firing in the same cycle is legal.
- L_B:
  - lsu_b* = out_b*; out_bready = lsu_bready.
  - On B fire, go to IDLE with last_grant=LSU.
- Non-granted master: arready/awready/wready/rvalid/bvalid held 0. Its valid may stay high indefinitely; it is served at the next IDLE.
- Grant is locked until the response handshake completes. Back-pressure on R/B holds state; no re-arbitration.
- Masters must hold valid until ready. If a granted valid drops (protocol violation), the arbiter stays in its state and waits.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; the downstream transaction is abandoned. A system-wide reset is assumed.

Test Plan:
- IFU alone: ifu_araddr=0x80000000 valid at cycle 0, slave arready=1 and returns rdata=0xDEADBEEF, rresp=0 -> out_arvalid first high at cycle 1; ifu_rvalid with 0xDEADBEEF, resp 0; lsu_* valids stay 0.
- After reset, IFU read (0x80000004) and LSU write (0x10000000, wdata 0x41, wstrb 0x1) requested in the same cycle:
  - IFU is served first, then LSU.
  - Repeating both simultaneously -> LSU first (strict alternation).
- LSU write where slave awready=0 for 3 cycles and wready=1 from cycle 1 -> W fires before AW; exactly one AW fire and one W fire; then a single lsu_bvalid with bresp=0.
- LSU with lsu_awvalid and lsu_arvalid both high -> write fully completes (B fire) before out_arvalid rises for the read.
- Read to 0x20000000, slave returns rresp=2'b11, rdata=0, with ifu_rready low for 4 cycles:
  - ifu_rvalid held high with resp 2'b11 through the stall.
  - No other grant occurs until rready=1, then IDLE.
- rst driven low asynchronously mid-cycle while in L_B -> all out_*valid and lsu_*/ifu_* ready/valid go 0 immediately; after release the next request is granted IFU-first.
